// File: rtl/concat_cmd_sched_if.sv
// Command bus between the concat scheduler and the feature read/write DMA engines.
// Latency: none (signal bundle only).
// Backpressure: rd_cmd_ready / wr_cmd_ready stall the scheduler; wr_done returns write credits.
// Ports: master = scheduler side (drives descriptors); slave = DMA side (drives ready and wr_done).
interface concat_cmd_sched_if #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) ();
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic [DIM_W-1:0]  rd_cmd_len;
    logic              rd_cmd_tag;
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_cmd_addr;
    logic [DIM_W-1:0]  wr_cmd_len;
    logic              wr_done;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_tag,
        input  rd_cmd_ready,
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        input  wr_cmd_ready, wr_done
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len, rd_cmd_tag,
        output rd_cmd_ready,
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        output wr_cmd_ready, wr_done
    );
endinterface

// File: rtl/concat_cmd_sched.sv
// Walks every (channel-group, row) line of a CLS-token concat job and issues write, CLS-read, feature-read descriptors.
// Latency: first wr_cmd_valid 2 cycles after start; done 1 cycle after the last outstanding write completes.
// Backpressure: holds descriptors stable until ready; stops issuing lines while MAX_OUTSTANDING writes are in flight.
// Ports: clk/rst_n (async active-low), start + cfg_* job setup (latched on accept), busy/done status,
//        cmd = master side of concat_cmd_sched_if (rd/wr descriptor handshakes, wr_done completions).
// Optional: define CONCAT_SCHED_PERF_EN to add perf_busy_cyc / perf_stall_cyc saturating counters.
module concat_cmd_sched #(
    parameter int ADDR_W          = 32,
    parameter int DIM_W           = 16,
    parameter int PIX_BYTES       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_win,
    input  logic [DIM_W-1:0]  cfg_hin,
    input  logic [DIM_W-1:0]  cfg_chg,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_in_surf,
    input  logic [ADDR_W-1:0] cfg_in_line,
    input  logic [ADDR_W-1:0] cfg_cls_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_out_surf,
    input  logic [ADDR_W-1:0] cfg_out_line,
    output logic              busy,
    output logic              done,
    concat_cmd_sched_if.master cmd
`ifdef CONCAT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, CHK, WR, RCLS, RFEAT, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [DIM_W-1:0]  win_q, hin_q, chg_q;
    logic [ADDR_W-1:0] in_surf_q, in_line_q, out_surf_q, out_line_q;
    logic [DIM_W-1:0]  g_cnt, h_cnt;
    logic [ADDR_W-1:0] g_out, g_in, h_out, h_in, cls_acc;
    logic [OW-1:0]     outst, outst_nxt;

    logic              accept, wr_hs, rd_hs, at_cap, last_h, last_g;
    logic [DIM_W-1:0]  win_p1;

    assign accept = (state == IDLE) && start;
    assign wr_hs  = cmd.wr_cmd_valid && cmd.wr_cmd_ready;
    assign rd_hs  = cmd.rd_cmd_valid && cmd.rd_cmd_ready;
    assign at_cap = (outst == OW'(MAX_OUTSTANDING));
    assign last_h = (h_cnt == hin_q - DIM_W'(1));
    assign last_g = (g_cnt == chg_q - DIM_W'(1));
    // Output width is one pixel wider (CLS column); carry out of DIM_W is dropped.
    assign win_p1 = win_q + DIM_W'(1);

    // Outstanding writes: a completion in the same cycle as a new write cancels out,
    // and stray completions at zero are ignored.
    always_comb begin
        outst_nxt = outst;
        if (wr_hs && !cmd.wr_done)
            outst_nxt = outst + OW'(1);
        else if (!wr_hs && cmd.wr_done && (outst != '0))
            outst_nxt = outst - OW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            outst <= '0;
        end else begin
            state <= state_nxt;
            outst <= outst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CHK;
            CHK:   state_nxt = ((win_q == '0) || (hin_q == '0) || (chg_q == '0)) ? DONE : WR;
            WR:    if (wr_hs) state_nxt = RCLS;
            RCLS:  if (rd_hs) state_nxt = RFEAT;
            RFEAT: if (rd_hs) state_nxt = (last_h && last_g) ? DRAIN : WR;
            // Look at the post-update count so done follows the final completion by one cycle.
            DRAIN: if (outst_nxt == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy             = (state != IDLE);
        done             = (state == DONE);
        cmd.wr_cmd_valid = 1'b0;
        cmd.wr_cmd_addr  = '0;
        cmd.wr_cmd_len   = '0;
        cmd.rd_cmd_valid = 1'b0;
        cmd.rd_cmd_addr  = '0;
        cmd.rd_cmd_len   = '0;
        cmd.rd_cmd_tag   = 1'b0;
        case (state)
            WR: begin
                cmd.wr_cmd_valid = !at_cap;
                cmd.wr_cmd_addr  = h_out;
                cmd.wr_cmd_len   = win_p1;
            end
            RCLS: begin
                cmd.rd_cmd_valid = 1'b1;
                cmd.rd_cmd_addr  = cls_acc;
                cmd.rd_cmd_len   = DIM_W'(1);
                cmd.rd_cmd_tag   = 1'b0;
            end
            RFEAT: begin
                cmd.rd_cmd_valid = 1'b1;
                cmd.rd_cmd_addr  = h_in;
                cmd.rd_cmd_len   = win_q;
                cmd.rd_cmd_tag   = 1'b1;
            end
            default: ;
        endcase
    end

    // Line walker: g accumulators hold the surface start, h accumulators the current line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            hin_q      <= '0;
            chg_q      <= '0;
            in_surf_q  <= '0;
            in_line_q  <= '0;
            out_surf_q <= '0;
            out_line_q <= '0;
            g_cnt      <= '0;
            h_cnt      <= '0;
            g_out      <= '0;
            g_in       <= '0;
            h_out      <= '0;
            h_in       <= '0;
            cls_acc    <= '0;
        end else if (accept) begin
            win_q      <= cfg_win;
            hin_q      <= cfg_hin;
            chg_q      <= cfg_chg;
            in_surf_q  <= cfg_in_surf;
            in_line_q  <= cfg_in_line;
            out_surf_q <= cfg_out_surf;
            out_line_q <= cfg_out_line;
            g_cnt      <= '0;
            h_cnt      <= '0;
            g_out      <= cfg_out_base;
            g_in       <= cfg_in_base;
            h_out      <= cfg_out_base;
            h_in       <= cfg_in_base;
            cls_acc    <= cfg_cls_base;
        end else if ((state == RFEAT) && rd_hs) begin
            if (last_h) begin
                h_cnt   <= '0;
                g_cnt   <= g_cnt + DIM_W'(1);
                g_out   <= g_out + out_surf_q;
                g_in    <= g_in + in_surf_q;
                h_out   <= g_out + out_surf_q;
                h_in    <= g_in + in_surf_q;
                cls_acc <= cls_acc + ADDR_W'(PIX_BYTES);
            end else begin
                h_cnt <= h_cnt + DIM_W'(1);
                h_out <= h_out + out_line_q;
                h_in  <= h_in + in_line_q;
            end
        end
    end

`ifdef CONCAT_SCHED_PERF_EN
    logic stall;
    assign stall = ((state == WR) && at_cap)
                 || (cmd.rd_cmd_valid && !cmd.rd_cmd_ready)
                 || (cmd.wr_cmd_valid && !cmd.wr_cmd_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (accept) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (stall && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_concat_cmd_sched.sv
// Scoreboard bench for concat_cmd_sched: expected descriptors are queued when a job is started
// and popped as the DUT hands them off; a responder returns wr_done and injects ready stalls.
module tb_concat_cmd_sched;

    localparam int ADDR_W = 32;
    localparam int DIM_W  = 16;
    localparam int PIX    = 32;
    localparam int MAXO   = 2;
    localparam logic [31:0] IN_BASE  = 32'h0;
    localparam logic [31:0] CLS_BASE = 32'h0200_0000;
    localparam logic [31:0] OUT_BASE = 32'h0800_0000;

    typedef struct packed {
        logic        kind;   // 1 = write, 0 = read
        logic [31:0] addr;
        logic [15:0] len;
        logic        tag;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_win = '0, cfg_hin = '0, cfg_chg = '0;
    logic [31:0] cfg_in_base = '0, cfg_in_surf = '0, cfg_in_line = '0, cfg_cls_base = '0;
    logic [31:0] cfg_out_base = '0, cfg_out_surf = '0, cfg_out_line = '0;
    logic        busy, done;

    concat_cmd_sched_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    concat_cmd_sched #(
        .ADDR_W(ADDR_W), .DIM_W(DIM_W), .PIX_BYTES(PIX), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_win(cfg_win), .cfg_hin(cfg_hin), .cfg_chg(cfg_chg),
        .cfg_in_base(cfg_in_base), .cfg_in_surf(cfg_in_surf), .cfg_in_line(cfg_in_line),
        .cfg_cls_base(cfg_cls_base),
        .cfg_out_base(cfg_out_base), .cfg_out_surf(cfg_out_surf), .cfg_out_line(cfg_out_line),
        .busy(busy), .done(done), .cmd(bus)
    );

    always #5 clk = ~clk;

    cmd_t exp_q[$];
    int   due_q[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0, first_vld = -1, done_cyc = 0, last_wrdone = 0;
    int   n_wr = 0, n_rd = 0, n_done = 0, manual = 0;
    bit   auto_done = 1'b1, stall_en = 1'b0, rd_hold = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic sb_pop(input string tag, input cmd_t c);
        if (exp_q.size() == 0)
            chk({tag, "_extra"}, 64'(c), '1);
        else
            chk(tag, 64'(c), 64'(exp_q.pop_front()));
    endtask

    // Responder: ready generation and write completions, driven just after the active edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        bus.rd_cmd_ready = rd_hold ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
        bus.wr_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            bus.wr_done = 1'b1;
        end else if (manual > 0) begin
            manual--;
            bus.wr_done = 1'b1;
        end else begin
            bus.wr_done = 1'b0;
        end
    end

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic [63:0] wr_saved, rd_saved;
    bit          wr_stall_v = 1'b0, rd_stall_v = 1'b0;
    always @(negedge clk) begin : mon
        cmd_t c;
        if (!rst_n) begin
            wr_stall_v = 1'b0;
            rd_stall_v = 1'b0;
        end else begin
            if (bus.rd_cmd_valid || bus.wr_cmd_valid) begin
                chk("one_vld", 64'(bus.rd_cmd_valid & bus.wr_cmd_valid), 64'd0);
                if (first_vld < 0) first_vld = cyc;
            end
            if (wr_stall_v)
                chk("wr_stable", 64'({bus.wr_cmd_valid, bus.wr_cmd_addr, bus.wr_cmd_len}), wr_saved);
            if (rd_stall_v)
                chk("rd_stable", 64'({bus.rd_cmd_valid, bus.rd_cmd_addr, bus.rd_cmd_len, bus.rd_cmd_tag}), rd_saved);
            wr_stall_v = bus.wr_cmd_valid && !bus.wr_cmd_ready;
            rd_stall_v = bus.rd_cmd_valid && !bus.rd_cmd_ready;
            wr_saved   = 64'({bus.wr_cmd_valid, bus.wr_cmd_addr, bus.wr_cmd_len});
            rd_saved   = 64'({bus.rd_cmd_valid, bus.rd_cmd_addr, bus.rd_cmd_len, bus.rd_cmd_tag});
            if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
                c.kind = 1'b1; c.addr = bus.wr_cmd_addr; c.len = bus.wr_cmd_len; c.tag = 1'b0;
                sb_pop("wr_cmd", c);
                n_wr++;
                if (auto_done) due_q.push_back(cyc + 5);
            end
            if (bus.rd_cmd_valid && bus.rd_cmd_ready) begin
                c.kind = 1'b0; c.addr = bus.rd_cmd_addr; c.len = bus.rd_cmd_len; c.tag = bus.rd_cmd_tag;
                sb_pop("rd_cmd", c);
                n_rd++;
            end
            if (bus.wr_done) last_wrdone = cyc;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic set_cfg(input logic [15:0] win, input logic [15:0] hin, input logic [15:0] chg,
                           input logic [31:0] in_surf, input logic [31:0] in_line,
                           input logic [31:0] out_surf, input logic [31:0] out_line);
        cfg_win = win; cfg_hin = hin; cfg_chg = chg;
        cfg_in_base = IN_BASE; cfg_in_surf = in_surf; cfg_in_line = in_line;
        cfg_cls_base = CLS_BASE;
        cfg_out_base = OUT_BASE; cfg_out_surf = out_surf; cfg_out_line = out_line;
    endtask

    // Reference model: direct multiply form of the line addresses, g outer, h inner.
    task automatic push_job();
        cmd_t c;
        for (int g = 0; g < int'(cfg_chg); g++) begin
            for (int h = 0; h < int'(cfg_hin); h++) begin
                c.kind = 1'b1; c.tag = 1'b0;
                c.addr = cfg_out_base + 32'(g) * cfg_out_surf + 32'(h) * cfg_out_line;
                c.len  = cfg_win + 16'd1;
                exp_q.push_back(c);
                c.kind = 1'b0; c.tag = 1'b0;
                c.addr = cfg_cls_base + 32'(g) * 32'(PIX);
                c.len  = 16'd1;
                exp_q.push_back(c);
                c.kind = 1'b0; c.tag = 1'b1;
                c.addr = cfg_in_base + 32'(g) * cfg_in_surf + 32'(h) * cfg_in_line;
                c.len  = cfg_win;
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic do_start();
        first_vld = -1;
        n_wr = 0; n_rd = 0; n_done = 0;
        @(posedge clk);
        #1 start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(n_done), 64'd1);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ctl"}, 64'({busy, done, bus.rd_cmd_valid, bus.wr_cmd_valid, bus.rd_cmd_tag,
                               bus.rd_cmd_len, bus.wr_cmd_len}), 64'd0);
        chk({tag, "_addr"}, {bus.rd_cmd_addr, bus.wr_cmd_addr}, 64'd0);
    endtask

    task automatic run_t1(input string tag);
        set_cfg(16'd16, 16'd1, 16'd1, 32'd0, 32'd0, 32'd0, 32'd544);
        push_job();
        do_start();
        wait_done({tag, "_done"}, 200);
        chk({tag, "_first_lat"}, 64'(first_vld - start_cyc), 64'd2);
        chk({tag, "_done_lat"}, 64'(done_cyc - last_wrdone), 64'd1);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_counts"}, 64'({n_wr, n_rd}), {32'd1, 32'd2});
        @(negedge clk);
        chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bus.rd_cmd_ready = 1'b1;
        bus.wr_cmd_ready = 1'b1;
        bus.wr_done      = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single line, unstalled
        run_t1("t1");

        // 2: 4 groups x 2 rows; a second start mid-job with altered cfg must be ignored
        set_cfg(16'd16, 16'd2, 16'd4, 32'd1024, 32'd512, 32'd1088, 32'd544);
        push_job();
        do_start();
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        cfg_chg = 16'd7; cfg_out_base = 32'h1234_0000; cfg_in_line = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t2_done", 1000);
        chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t2_counts", 64'({n_wr, n_rd}), {32'd8, 32'd16});
        repeat (10) @(negedge clk);
        chk("t2_single_done", 64'(n_done), 64'd1);
        chk("t2_idle", 64'(busy), 64'd0);

        // 3: completions withheld -> issue stops at the in-flight cap
        auto_done = 1'b0;
        set_cfg(16'd16, 16'd2, 16'd4, 32'd1024, 32'd512, 32'd1088, 32'd544);
        push_job();
        do_start();
        repeat (40) @(negedge clk);
        chk("t3_capped_counts", 64'({n_wr, n_rd}), {32'd2, 32'd4});
        chk("t3_capped_vld", 64'({bus.wr_cmd_valid, busy}), 64'b01);
        manual = 1;
        repeat (40) @(negedge clk);
        chk("t3_release_one", 64'({n_wr, n_rd}), {32'd3, 32'd6});
        chk("t3_recapped_vld", 64'(bus.wr_cmd_valid), 64'd0);
        auto_done = 1'b1;
        manual = 2;
        wait_done("t3_done", 1000);
        chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t3_counts", 64'({n_wr, n_rd}), {32'd8, 32'd16});

        // 4: random ready stalls on both channels
        stall_en = 1'b1;
        set_cfg(16'd16, 16'd2, 16'd4, 32'd1024, 32'd512, 32'd1088, 32'd544);
        push_job();
        do_start();
        wait_done("t4_done", 3000);
        chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_counts", 64'({n_wr, n_rd}), {32'd8, 32'd16});
        stall_en = 1'b0;

        // 5: empty job
        set_cfg(16'd16, 16'd2, 16'd0, 32'd1024, 32'd512, 32'd1088, 32'd544);
        do_start();
        wait_done("t5_done", 50);
        chk("t5_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        chk("t5_no_vld", 64'({n_wr, first_vld + 1}), 64'd0);

        // 6: reset while a feature read is pending, then rerun job 1
        set_cfg(16'd16, 16'd1, 16'd1, 32'd0, 32'd0, 32'd0, 32'd544);
        push_job();
        do_start();
        begin
            int k = 0;
            while (!(bus.rd_cmd_valid && !bus.rd_cmd_tag && bus.rd_cmd_ready) && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        rd_hold = 1'b1;
        @(negedge clk);
        chk("t6_in_rfeat", 64'({bus.rd_cmd_valid, bus.rd_cmd_tag}), 64'b11);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outs("t6_rst");
        exp_q.delete();
        due_q.delete();
        manual  = 0;
        rd_hold = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outs("t6_rst_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_t1("t6_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/concat_cmd_sched.md
Name: concat_cmd_sched

Overview:
- Command scheduler for the CLS-token concat engine: output row = CLS token pixel at w=0, then input pixels shifted to w+1.
- Walks every (channel-group, row) line of a concat job and issues ordered read- and write-burst descriptors to the feature DMA.
- Caps the number of in-flight output lines and reports job completion to the CSR block.
- Sits between the CSR register file and the AXI read/write DMA engines on the shared HBM/DDR port.

Parameters:
ADDR_W, 32, byte-address width of all base/stride/command address fields
DIM_W, 16, width of the Win/Hin/channel-group counts and of the command length fields
PIX_BYTES, 32, bytes per mapped pixel (Tout*MAX_DAT_DW*Tb/8); fixed stride between consecutive w positions
MAX_OUTSTANDING, 4, maximum output lines with write command issued but wr_done not yet returned (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job start; ignored while busy=1
cfg_win  in  DIM_W  input width in pixels; output width is cfg_win+1
cfg_hin  in  DIM_W  rows per surface
cfg_chg  in  DIM_W  channel groups (CH/Tout, rounded up)
cfg_in_base, cfg_in_surf, cfg_in_line  in  ADDR_W each  input base address, surface stride, line stride
cfg_cls_base  in  ADDR_W  CLS token base; group g is at cfg_cls_base + g*PIX_BYTES
cfg_out_base, cfg_out_surf, cfg_out_line  in  ADDR_W each  output base address, surface stride, line stride
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job completion
rd_cmd_valid / rd_cmd_ready  out / in  1 / 1  read descriptor handshake
rd_cmd_addr  out  ADDR_W  read burst start byte address
rd_cmd_len  out  DIM_W  read length in pixels
rd_cmd_tag  out  1  0 = CLS token read, 1 = feature read
wr_cmd_valid / wr_cmd_ready  out / in  1 / 1  write descriptor handshake
wr_cmd_addr  out  ADDR_W  output line start byte address
wr_cmd_len  out  DIM_W  write length in pixels (cfg_win+1)
wr_done  in  1  one-cycle pulse per completed write burst (B response)

Behaviour:
- Reset values: busy, done, rd_cmd_valid, wr_cmd_valid = 0. Address, len and tag outputs = 0. All counters and accumulators = 0. FSM state = IDLE.
- All cfg_* inputs are latched on the cycle start is accepted. Later cfg changes do not affect the running job.
- Loop order: channel group g outer (0..chg-1), row h inner (0..hin-1).
- Per-line addresses are kept in accumulators (no multipliers):
  - out = out_base + g*out_surf + h*out_line
  - in = in_base + g*in_surf + h*in_line
  - cls = cls_base + g*PIX_BYTES
  - h-accumulators reload from the g-accumulators when h wraps.
- FSM states:
  - IDLE: wait for start.
  - CHK: if win, hin or chg == 0, go to DONE with no commands issued. Otherwise go to WR.
  - WR: wait while outstanding == MAX_OUTSTANDING, with wr_cmd_valid held low during the wait. Otherwise drive wr_cmd(out, win+1). Move to RCLS on the handshake.
  - RCLS: drive rd_cmd(cls, len 1, tag 0). Move to RFEAT on the handshake.
  - RFEAT: drive rd_cmd(in, len win, tag 1). On the handshake, advance h/g; if it was the last line go to DRAIN, else go to WR.
  - DRAIN: wait until outstanding == 0.
  - DONE: pulse done for one cycle, clear busy, return to IDLE.
- Command ordering per line is strictly write, CLS read, feature read; the datapath relies on this order.
- Valid/ready rules:
  - Once a valid is raised, valid, addr, len and tag stay stable until ready.
  - Only one command channel is valid at a time.
  - Zero-wait handshake: one descriptor per cycle.
- Outstanding counter:
  - +1 on the wr_cmd handshake, -1 on wr_done.
  - Both in the same cycle: counter unchanged.
  - wr_done while the counter is 0 is ignored (counter saturates at 0).
- Arithmetic: all address sums are modulo 2^ADDR_W (wrap silently). cfg_win+1 is computed in DIM_W+1 bits and truncated to DIM_W (cfg_win = 2^DIM_W-1 is illegal).
- Latency: first wr_cmd_valid appears 2 cycles after start (IDLE->CHK->WR). done asserts the cycle after the last wr_done is counted in DRAIN.
- Reset asserted mid-job: immediate return to reset values. Descriptors already accepted downstream are not tracked. A subsequent start runs cleanly.

Optional Feature:
CONCAT_SCHED_PERF_EN:
- Defined: adds outputs perf_busy_cyc (32 bits, counts cycles busy=1) and perf_stall_cyc (32 bits, counts cycles spent in WR blocked by the outstanding limit or with valid high and ready low on either channel).
- Both counters clear on an accepted start, hold their value after done, and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. win=16, hin=1, chg=1, in_base=0, cls_base=0x200_0000, out_base=0x800_0000, out_line=544, ready tied 1, wr_done returned 5 cycles after each write -> exactly wr(0x800_0000,17), rd(0x200_0000,1,tag0), rd(0x0,16,tag1); done one cycle after the wr_done.
2. win=16, hin=2, chg=4, in_surf=1024, in_line=512, out_surf=1088, out_line=544 -> 8 lines, g-outer order; line (g=2,h=1) gives wr 0x800_0AA0, rd cls 0x200_0040, rd feat 0xA00.
3. MAX_OUTSTANDING=2, wr_done held low, same config as test 2 -> exactly 2 write and 4 read commands issued, then wr_cmd_valid stays 0; a single wr_done pulse releases exactly one more line.
4. Random ready stalls on both channels -> addr/len/tag stable while valid and not ready; command sequence identical to the zero-stall run.
5. start with chg=0 -> no valid on either channel; done pulses 2 cycles after start; start pulsed again while busy in test 2 -> ignored, single done.
6. rst_n low mid-RFEAT, then restart with test 1 config -> all outputs 0 during reset; rerun produces test 1's exact sequence.
